// File: rtl/d_sram_to_sram_like_if.sv
// SRAM-like split-transaction data bus: address phase (req/addr_ok) and
// data phase (data_ok/rdata). The bridge is the master, memory is the slave.
interface d_sram_to_sram_like_if;
  logic        data_req;
  logic        data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_addr_ok;
  logic [31:0] data_rdata;
  logic        data_data_ok;

  modport master (
    output data_req, data_wr, data_size, data_addr, data_wdata,
    input  data_addr_ok, data_rdata, data_data_ok
  );

  modport slave (
    input  data_req, data_wr, data_size, data_addr, data_wdata,
    output data_addr_ok, data_rdata, data_data_ok
  );
endinterface

// File: rtl/d_sram_to_sram_like.sv
// Data-side bridge from the MEM stage's single-cycle SRAM access to the
// split-transaction SRAM-like bus. Stalls the pipeline while an access is
// outstanding and hands load data to MEM/WB in the cycle the stall releases.
module d_sram_to_sram_like #(
  parameter int unsigned TIMEOUT = 255  // DATA-state cycles before bus_err (1..65535)
) (
  input  logic        clk,
  input  logic        rst,               // synchronous, active-low
  input  logic        data_sram_en,
  input  logic [3:0]  data_sram_wen,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  input  logic [1:0]  data_sram_size,
  output logic [31:0] data_sram_rdata,
  input  logic        longest_stall,
  output logic        d_stall,
  output logic        bus_err,
  d_sram_to_sram_like_if.master bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,  // address phase: req follows en combinationally
    DATA = 2'd1,  // address accepted, waiting for data_ok
    DONE = 2'd2   // access complete, pipeline still held by another stall
  } state_e;

  localparam logic [15:0] TIMEOUT_W = 16'(TIMEOUT);

  state_e      state_q, state_d;
  logic [31:0] rdata_buf_q, rdata_buf_d;
  logic [15:0] wait_cnt_q, wait_cnt_d;
  logic        bus_err_q, bus_err_d;

  // State, captured load data, timeout counter and sticky error flag.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    if (!rst) begin
      state_q     <= IDLE;
      rdata_buf_q <= '0;
      wait_cnt_q  <= '0;
      bus_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      rdata_buf_q <= rdata_buf_d;
      wait_cnt_q  <= wait_cnt_d;
      bus_err_q   <= bus_err_d;
    end
  end

  // Next-state, load-data capture and DATA-phase timeout counting.
  always_comb begin
    // NOTE: defaults first; every path then assigns every variable, so no latch.
    state_d     = state_q;
    rdata_buf_d = rdata_buf_q;
    wait_cnt_d  = wait_cnt_q;

    case (state_q)
      IDLE: begin
        if (data_sram_en && bus.data_addr_ok) begin
          state_d    = DATA;
          wait_cnt_d = '0;
        end
      end
      DATA: begin
        if (wait_cnt_q != 16'hFFFF) begin
          wait_cnt_d = wait_cnt_q + 16'd1;
        end
        if (bus.data_data_ok) begin
          rdata_buf_d = bus.data_rdata;
          state_d     = longest_stall ? DONE : IDLE;
        end
      end
      DONE: begin
        // The access already finished; only wait for the rest of the pipeline.
        if (!longest_stall) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Error is raised on the edge the counter reaches TIMEOUT; the access
    // itself keeps waiting for data_ok.
    bus_err_d = bus_err_q | ((state_q == DATA) && (wait_cnt_d == TIMEOUT_W));
  end

  // Address-phase request only from IDLE; forced low while in reset.
  assign bus.data_req   = rst && data_sram_en && (state_q == IDLE);
  assign bus.data_wr    = |data_sram_wen;
  assign bus.data_size  = data_sram_size;
  assign bus.data_addr  = data_sram_addr;
  assign bus.data_wdata = data_sram_wdata;

  // Stall while requesting or waiting; release in the data_ok cycle itself.
  assign d_stall = rst && data_sram_en &&
                   ((state_q == IDLE) || ((state_q == DATA) && !bus.data_data_ok));

  // Bypass the buffer in the data_ok cycle so WB sees the data on release.
  assign data_sram_rdata = !rst ? 32'd0 :
                           ((state_q == DATA) && bus.data_data_ok) ? bus.data_rdata
                                                                  : rdata_buf_q;

  assign bus_err = bus_err_q;

endmodule

// File: tb/tb_d_sram_to_sram_like.sv
// Self-checking bench for d_sram_to_sram_like: expected load data is queued
// when the slave response is driven and popped when the pipeline releases.
module tb_d_sram_to_sram_like;
  localparam int unsigned TO   = 8;
  localparam logic [31:0] JUNK = 32'h0BAD_F00D;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [3:0]  wen;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [1:0]  size;
  logic        ls;
  logic [31:0] sram_rdata;
  logic        d_stall;
  logic        bus_err;

  int n_tests = 0;
  int n_fail  = 0;
  int txn_cnt = 0;
  logic [31:0] exp_q[$];

  d_sram_to_sram_like_if bus ();

  d_sram_to_sram_like #(.TIMEOUT(TO)) dut (
    .clk             (clk),
    .rst             (rst),
    .data_sram_en    (en),
    .data_sram_wen   (wen),
    .data_sram_addr  (addr),
    .data_sram_wdata (wdata),
    .data_sram_size  (size),
    .data_sram_rdata (sram_rdata),
    .longest_stall   (ls),
    .d_stall         (d_stall),
    .bus_err         (bus_err),
    .bus             (bus)
  );

  always #5 clk = ~clk;

  // Count accepted address phases (bus transactions).
  always @(posedge clk) begin
    if (rst && bus.data_req && bus.data_addr_ok) txn_cnt <= txn_cnt + 1;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic drive_quiet();
    en = 1'b0; wen = 4'b0; addr = '0; wdata = '0; size = 2'b00; ls = 1'b0;
    bus.data_addr_ok = 1'b0; bus.data_data_ok = 1'b0; bus.data_rdata = JUNK;
  endtask

  task automatic pop_exp(output logic [31:0] e);
    if (exp_q.size() == 0) e = 'x;
    else e = exp_q.pop_front();
  endtask

  // Drives one access and reports what was observed; callers compare.
  task automatic run_access(
    input  logic [31:0] a, input logic [3:0] w, input logic [31:0] wd, input logic [1:0] sz,
    input  int addr_delay, input int data_delay, input logic [31:0] rd, input int ls_extra,
    output int req_cyc, output int stall_cyc, output logic [31:0] rel_rdata,
    output logic wr_obs, output logic [1:0] size_obs, output logic [31:0] addr_obs,
    output logic [31:0] wdata_obs, output int held_bad, output bit released);
    req_cyc = 0; stall_cyc = 0; held_bad = 0; released = 0; rel_rdata = 'x;
    wr_obs = 'x; size_obs = 'x; addr_obs = 'x; wdata_obs = 'x;
    @(posedge clk); #1;
    en = 1'b1; wen = w; addr = a; wdata = wd; size = sz; ls = 1'b0;
    for (int i = 0; i <= addr_delay; i++) begin
      bus.data_addr_ok = (i == addr_delay);
      @(negedge clk);
      if (i == 0) begin
        wr_obs = bus.data_wr; size_obs = bus.data_size;
        addr_obs = bus.data_addr; wdata_obs = bus.data_wdata;
      end
      if (bus.data_req) req_cyc++;
      if (d_stall) stall_cyc++;
      @(posedge clk); #1;
    end
    bus.data_addr_ok = 1'b0;
    for (int i = 0; i < data_delay; i++) begin
      @(negedge clk);
      if (bus.data_req) req_cyc++;
      if (d_stall) stall_cyc++;
      @(posedge clk); #1;
    end
    bus.data_data_ok = 1'b1; bus.data_rdata = rd; ls = (ls_extra > 0);
    @(negedge clk);
    if (bus.data_req) req_cyc++;
    if (d_stall) stall_cyc++;
    if (!d_stall && !ls) begin released = 1; rel_rdata = sram_rdata; end
    if (ls_extra > 0) begin
      for (int j = 1; j <= ls_extra + 1; j++) begin
        @(posedge clk); #1;
        bus.data_data_ok = 1'b0; bus.data_rdata = JUNK; ls = (j <= ls_extra);
        @(negedge clk);
        if (bus.data_req) req_cyc++;
        if (d_stall) stall_cyc++;
        if (sram_rdata !== rd) held_bad++;
        if (!d_stall && !ls && !released) begin released = 1; rel_rdata = sram_rdata; end
      end
    end
    @(posedge clk); #1;
    drive_quiet();
  endtask

  task automatic test_reset();
    drive_quiet();
    rst = 1'b0; en = 1'b1; bus.data_addr_ok = 1'b1;
    @(negedge clk);
    n_tests++; if (bus.data_req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b want 0", bus.data_req); end
    n_tests++; if (d_stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b want 0", d_stall); end
    n_tests++; if (sram_rdata !== 32'd0) begin n_fail++; $display("FAIL reset_rdata: got %h want 0", sram_rdata); end
    n_tests++; if (bus_err !== 1'b0) begin n_fail++; $display("FAIL reset_bus_err: got %b want 0", bus_err); end
    @(posedge clk); #1;
    drive_quiet(); rst = 1'b1;
    @(negedge clk);
    n_tests++; if (sram_rdata !== 32'd0) begin n_fail++; $display("FAIL post_reset_rdata: got %h want 0", sram_rdata); end
  endtask

  task automatic test_load_min();
    int req_c, stall_c, held, c0; logic [31:0] rel, e, ao, wdo; logic wr; logic [1:0] so; bit rl;
    c0 = txn_cnt;
    exp_q.push_back(32'hDEAD_BEEF);
    run_access(32'h1000, 4'b0000, 32'h0, 2'b10, 0, 0, 32'hDEAD_BEEF, 0,
               req_c, stall_c, rel, wr, so, ao, wdo, held, rl);
    pop_exp(e);
    n_tests++; if (rl !== 1'b1) begin n_fail++; $display("FAIL load_release: no release within budget"); end
    n_tests++; if (rel !== e) begin n_fail++; $display("FAIL load_rdata: got %h want %h", rel, e); end
    n_tests++; if (stall_c != 1) begin n_fail++; $display("FAIL load_stall_cycles: got %0d want 1", stall_c); end
    n_tests++; if (req_c != 1) begin n_fail++; $display("FAIL load_req_cycles: got %0d want 1", req_c); end
    n_tests++; if (wr !== 1'b0) begin n_fail++; $display("FAIL load_wr: got %b want 0", wr); end
    n_tests++; if (ao !== 32'h1000) begin n_fail++; $display("FAIL load_addr: got %h want 00001000", ao); end
    n_tests++; if (txn_cnt - c0 != 1) begin n_fail++; $display("FAIL load_txn: got %0d want 1", txn_cnt - c0); end
  endtask

  task automatic test_store_delayed();
    int req_c, stall_c, held, c0; logic [31:0] rel, ao, wdo; logic wr; logic [1:0] so; bit rl;
    c0 = txn_cnt;
    run_access(32'h2002, 4'b0011, 32'h0000_A5C3, 2'b01, 3, 2, JUNK, 0,
               req_c, stall_c, rel, wr, so, ao, wdo, held, rl);
    n_tests++; if (req_c != 4) begin n_fail++; $display("FAIL store_req_cycles: got %0d want 4", req_c); end
    n_tests++; if (stall_c != 6) begin n_fail++; $display("FAIL store_stall_cycles: got %0d want 6", stall_c); end
    n_tests++; if (wr !== 1'b1) begin n_fail++; $display("FAIL store_wr: got %b want 1", wr); end
    n_tests++; if (so !== 2'b01) begin n_fail++; $display("FAIL store_size: got %b want 01", so); end
    n_tests++; if (ao !== 32'h2002) begin n_fail++; $display("FAIL store_addr: got %h want 00002002", ao); end
    n_tests++; if (wdo !== 32'h0000_A5C3) begin n_fail++; $display("FAIL store_wdata: got %h want 0000a5c3", wdo); end
    n_tests++; if (rl !== 1'b1) begin n_fail++; $display("FAIL store_release: no release within budget"); end
    n_tests++; if (txn_cnt - c0 != 1) begin n_fail++; $display("FAIL store_txn: got %0d want 1", txn_cnt - c0); end
  endtask

  task automatic test_done_hold();
    int req_c, stall_c, held, c0; logic [31:0] rel, e, ao, wdo; logic wr; logic [1:0] so; bit rl;
    c0 = txn_cnt;
    exp_q.push_back(32'h1357_9BDF);
    run_access(32'h3000, 4'b0000, 32'h0, 2'b10, 0, 0, 32'h1357_9BDF, 2,
               req_c, stall_c, rel, wr, so, ao, wdo, held, rl);
    pop_exp(e);
    n_tests++; if (rl !== 1'b1) begin n_fail++; $display("FAIL done_release: no release within budget"); end
    n_tests++; if (rel !== e) begin n_fail++; $display("FAIL done_rdata: got %h want %h", rel, e); end
    n_tests++; if (held != 0) begin n_fail++; $display("FAIL done_rdata_held: %0d cycles wrong want 0", held); end
    n_tests++; if (stall_c != 1) begin n_fail++; $display("FAIL done_stall_cycles: got %0d want 1", stall_c); end
    n_tests++; if (req_c != 1) begin n_fail++; $display("FAIL done_req_cycles: got %0d want 1", req_c); end
    n_tests++; if (txn_cnt - c0 != 1) begin n_fail++; $display("FAIL done_txn: got %0d want 1", txn_cnt - c0); end
  endtask

  task automatic test_reset_mid_access();
    int c0;
    c0 = txn_cnt;
    @(posedge clk); #1;
    en = 1'b1; addr = 32'h4000; size = 2'b10; bus.data_addr_ok = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    bus.data_addr_ok = 1'b0;
    @(negedge clk);
    n_tests++; if (d_stall !== 1'b1) begin n_fail++; $display("FAIL rstmid_wait_stall: got %b want 1", d_stall); end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    n_tests++; if (d_stall !== 1'b0) begin n_fail++; $display("FAIL rstmid_stall: got %b want 0", d_stall); end
    n_tests++; if (bus.data_req !== 1'b0) begin n_fail++; $display("FAIL rstmid_req: got %b want 0", bus.data_req); end
    @(posedge clk); #1;
    rst = 1'b1; en = 1'b0; bus.data_data_ok = 1'b1; bus.data_rdata = 32'hCAFE_F00D;
    @(negedge clk);
    n_tests++; if (sram_rdata !== 32'd0) begin n_fail++; $display("FAIL rstmid_late_rdata: got %h want 0", sram_rdata); end
    n_tests++; if (d_stall !== 1'b0) begin n_fail++; $display("FAIL rstmid_late_stall: got %b want 0", d_stall); end
    @(posedge clk); #1;
    drive_quiet();
    @(negedge clk);
    n_tests++; if (sram_rdata !== 32'd0) begin n_fail++; $display("FAIL rstmid_no_capture: got %h want 0", sram_rdata); end
    n_tests++; if (txn_cnt - c0 != 1) begin n_fail++; $display("FAIL rstmid_txn: got %0d want 1", txn_cnt - c0); end
  endtask

  task automatic test_back_to_back();
    int c0; logic [31:0] e;
    c0 = txn_cnt;
    @(posedge clk); #1;
    en = 1'b1; addr = 32'h6000; size = 2'b10; bus.data_addr_ok = 1'b1;
    @(negedge clk);
    n_tests++; if (bus.data_req !== 1'b1) begin n_fail++; $display("FAIL b2b_req1: got %b want 1", bus.data_req); end
    @(posedge clk); #1;
    bus.data_addr_ok = 1'b0; bus.data_data_ok = 1'b1; bus.data_rdata = 32'hAAAA_0001;
    exp_q.push_back(32'hAAAA_0001);
    @(negedge clk);
    pop_exp(e);
    n_tests++; if (d_stall !== 1'b0) begin n_fail++; $display("FAIL b2b_release1: stall got %b want 0", d_stall); end
    n_tests++; if (sram_rdata !== e) begin n_fail++; $display("FAIL b2b_rdata1: got %h want %h", sram_rdata, e); end
    n_tests++; if (bus.data_req !== 1'b0) begin n_fail++; $display("FAIL b2b_req_gap: got %b want 0", bus.data_req); end
    @(posedge clk); #1;
    addr = 32'h6004; bus.data_data_ok = 1'b0; bus.data_rdata = JUNK; bus.data_addr_ok = 1'b1;
    @(negedge clk);
    n_tests++; if (bus.data_req !== 1'b1) begin n_fail++; $display("FAIL b2b_req2: got %b want 1", bus.data_req); end
    n_tests++; if (d_stall !== 1'b1) begin n_fail++; $display("FAIL b2b_stall2: got %b want 1", d_stall); end
    @(posedge clk); #1;
    bus.data_addr_ok = 1'b0; bus.data_data_ok = 1'b1; bus.data_rdata = 32'h5555_0002;
    exp_q.push_back(32'h5555_0002);
    @(negedge clk);
    pop_exp(e);
    n_tests++; if (sram_rdata !== e) begin n_fail++; $display("FAIL b2b_rdata2: got %h want %h", sram_rdata, e); end
    @(posedge clk); #1;
    drive_quiet();
    @(negedge clk);
    n_tests++; if (txn_cnt - c0 != 2) begin n_fail++; $display("FAIL b2b_txn: got %0d want 2", txn_cnt - c0); end
  endtask

  task automatic test_timeout();
    int stall_bad; logic [31:0] e;
    stall_bad = 0;
    @(posedge clk); #1;
    en = 1'b1; addr = 32'h5000; size = 2'b10; bus.data_addr_ok = 1'b1;
    @(negedge clk);
    n_tests++; if (bus_err !== 1'b0) begin n_fail++; $display("FAIL to_initial: got %b want 0", bus_err); end
    @(posedge clk); #1;
    bus.data_addr_ok = 1'b0;
    for (int d = 1; d <= int'(TO) + 1; d++) begin
      @(negedge clk);
      if (d_stall !== 1'b1) stall_bad++;
      if (d == int'(TO)) begin
        n_tests++; if (bus_err !== 1'b0) begin n_fail++; $display("FAIL to_before: cycle %0d got %b want 0", d, bus_err); end
      end
      if (d == int'(TO) + 1) begin
        n_tests++; if (bus_err !== 1'b1) begin n_fail++; $display("FAIL to_set: cycle %0d got %b want 1", d, bus_err); end
      end
      @(posedge clk); #1;
    end
    n_tests++; if (stall_bad != 0) begin n_fail++; $display("FAIL to_stall: %0d cycles unstalled want 0", stall_bad); end
    bus.data_data_ok = 1'b1; bus.data_rdata = 32'h600D_BEEF;
    exp_q.push_back(32'h600D_BEEF);
    @(negedge clk);
    pop_exp(e);
    n_tests++; if (sram_rdata !== e) begin n_fail++; $display("FAIL to_rdata: got %h want %h", sram_rdata, e); end
    @(posedge clk); #1;
    drive_quiet();
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_tests++; if (bus_err !== 1'b1) begin n_fail++; $display("FAIL to_sticky: got %b want 1", bus_err); end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    n_tests++; if (bus_err !== 1'b0) begin n_fail++; $display("FAIL to_cleared: got %b want 0", bus_err); end
  endtask

  initial begin
    test_reset();
    test_load_min();
    test_store_delayed();
    test_done_hold();
    test_reset_mid_access();
    test_back_to_back();
    test_timeout();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
